// File: rtl/row_feeder.sv
// row_feeder: west-edge FIFO and sequencer that streams kernel-load and execute words into one MAC-array row.
module row_feeder #(
    parameter int bw      = 4,
    parameter int col     = 8,
    parameter int depth   = 16,
    parameter int inst_bw = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr,
    input  logic [bw-1:0]      in_data,
    output logic               full,
    output logic               empty,
    input  logic               start_load,
    input  logic               start_exec,
    input  logic [7:0]         exec_len,
    output logic [bw-1:0]      out_w,
    output logic [inst_bw-1:0] inst_w,
    output logic               busy,
    output logic               done
);
    localparam int aw = $clog2(depth);
    localparam logic [2:0] idle  = 3'd0;
    localparam logic [2:0] load  = 3'd1;
    localparam logic [2:0] exec  = 3'd2;
    localparam logic [2:0] drain = 3'd3;
    localparam logic [2:0] fin   = 3'd4;

    logic [2:0]    state, state_n;
    logic [bw-1:0] mem [depth];
    logic [aw-1:0] rd_ptr, wr_ptr;
    logic [aw:0]   count;
    logic [7:0]    remain;
    logic          pop, push;

    assign empty = count == '0;
    assign full  = count == (aw+1)'(depth);
    assign busy  = state != idle;
    assign pop   = (state == load || state == exec) && !empty;
    // a full FIFO still takes a word when a pop frees a slot in the same cycle
    assign push  = wr && (!full || pop);

    always_comb begin
        state_n = state;
        case (state)
            idle:    state_n = start_load ? load : start_exec ? (exec_len == 8'd0 ? fin : exec) : idle;
            load:    state_n = (pop && remain == 8'd1) ? fin : load;
            exec:    state_n = (pop && remain == 8'd1) ? drain : exec;
            drain:   state_n = remain == 8'd1 ? fin : drain;
            default: state_n = idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= idle;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            remain <= '0;
            out_w  <= '0;
            inst_w <= '0;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            rd_ptr <= rd_ptr + aw'(pop);
            wr_ptr <= wr_ptr + aw'(push);
            count  <= count + (aw+1)'(push) - (aw+1)'(pop);
            // the drain counter reuses the word counter once execute finishes
            remain <= state == idle ? (start_load ? 8'(col) : exec_len)
                    : (state == exec && state_n == drain) ? 8'(col)
                    : (pop || state == drain) ? remain - 8'd1 : remain;
            out_w  <= pop ? mem[rd_ptr] : '0;
            inst_w <= inst_bw'({pop && state == exec, pop && state == load});
            done   <= state == fin;
        end
    end
endmodule

// File: tb/tb_row_feeder.sv
// tb_row_feeder: directed stimulus with a queued scoreboard checked by a negedge output monitor.
module tb_row_feeder;
    logic       clk = 0, reset = 1, wr = 0, start_load = 0, start_exec = 0;
    logic [3:0] in_data = 0;
    logic [7:0] exec_len = 0;
    logic       full, empty, busy, done;
    logic [3:0] out_w;
    logic [1:0] inst_w;
    int checks = 0, errors = 0, cyc = 0;
    int first_cyc = -1, last_cyc = -1, done_cyc = -1, nvalid = 0;
    logic [5:0] exp_q[$];
    logic [5:0] e_w;
    logic [3:0] nw [8] = '{4'h3, 4'h1, 4'h4, 4'h1, 4'h5, 4'h9, 4'h2, 4'h6};
    int s;

    row_feeder dut (
        .clk(clk), .reset(reset), .wr(wr), .in_data(in_data), .full(full), .empty(empty),
        .start_load(start_load), .start_exec(start_exec), .exec_len(exec_len),
        .out_w(out_w), .inst_w(inst_w), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) if (reset) begin
        if (inst_w != 2'b00) begin
            nvalid++;
            if (first_cyc < 0) first_cyc = cyc;
            last_cyc = cyc;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got inst=%b data=%h expected none", inst_w, out_w);
            end else begin
                e_w = exp_q.pop_front();
                chk("word", {inst_w, out_w}, e_w);
            end
        end else chk("idle_zero", out_w, 0);
        if (done) done_cyc = cyc;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] d);
        wr = 1;
        in_data = d;
        tick();
        wr = 0;
    endtask

    task automatic expect_w(input logic [1:0] i, input logic [3:0] d);
        exp_q.push_back({i, d});
    endtask

    task automatic arm;
        first_cyc = -1;
        last_cyc = -1;
        done_cyc = -1;
        nvalid = 0;
    endtask

    task automatic start(input logic l, input logic e, input logic [7:0] len, output int sc);
        start_load = l;
        start_exec = e;
        exec_len = len;
        tick();
        start_load = 0;
        start_exec = 0;
        sc = cyc;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 60 && done_cyc < 0; i++) tick();
        if (done_cyc < 0) begin
            checks++;
            errors++;
            $display("FAIL %s: got no done expected done within 60 cycles", name);
        end
        tick();
    endtask

    initial begin
        #2 reset = 0;
        tick();
        tick();
        chk("rst_out", out_w, 0);
        chk("rst_inst", inst_w, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        reset = 1;
        tick();

        // mid-operation reset discards the three buffered words
        for (int i = 0; i < 3; i++) push(4'h7);
        arm();
        start(1, 0, 0, s);
        chk("mid_busy", busy, 1);
        reset = 0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_empty", empty, 1);
        chk("abort_inst", inst_w, 0);
        chk("abort_done", done, 0);
        tick();
        reset = 1;
        tick();

        for (int i = 1; i <= 8; i++) begin
            push(4'(i));
            expect_w(2'b01, 4'(i));
        end
        arm();
        start(1, 0, 0, s);
        wait_done("load");
        chk("load_first", first_cyc, s + 1);
        chk("load_last", last_cyc, s + 8);
        chk("load_done", done_cyc, s + 9);
        chk("load_n", nvalid, 8);
        chk("load_empty", empty, 1);
        chk("load_busy", busy, 0);

        for (int i = 0; i < 10; i++) begin
            push(4'hA);
            expect_w(2'b10, 4'hA);
        end
        arm();
        start(0, 1, 8'd10, s);
        wait_done("exec");
        chk("exec_first", first_cyc, s + 1);
        chk("exec_last", last_cyc, s + 10);
        chk("exec_done", done_cyc, s + 19);
        chk("exec_n", nvalid, 10);

        for (int i = 1; i <= 8; i++) expect_w(2'b01, 4'(i));
        for (int i = 1; i <= 3; i++) push(4'(i));
        arm();
        start(1, 0, 0, s);
        repeat (4) tick();
        for (int i = 4; i <= 8; i++) push(4'(i));
        wait_done("stall");
        chk("stall_n", nvalid, 8);
        chk("stall_last", last_cyc, s + 10);
        chk("stall_done", done_cyc, s + 11);

        for (int i = 0; i < 16; i++) begin
            if (i == 15) chk("full_at15", full, 0);
            push(4'(i));
        end
        chk("full_at16", full, 1);
        push(4'h5);
        chk("full_drop", full, 1);
        for (int i = 0; i < 8; i++) expect_w(2'b01, 4'(i));
        arm();
        start(1, 0, 0, s);
        for (int i = 0; i < 8; i++) begin
            wr = 1;
            in_data = nw[i];
            tick();
        end
        wr = 0;
        wait_done("full_load1");
        chk("full_kept", full, 1);
        for (int i = 8; i < 16; i++) expect_w(2'b01, 4'(i));
        arm();
        start(1, 0, 0, s);
        wait_done("full_load2");
        for (int i = 0; i < 8; i++) expect_w(2'b01, nw[i]);
        arm();
        start(1, 0, 0, s);
        wait_done("full_load3");
        chk("wrap_n", nvalid, 8);
        chk("wrap_empty", empty, 1);

        for (int i = 1; i <= 8; i++) begin
            push(4'(i));
            expect_w(2'b01, 4'(i));
        end
        arm();
        start(1, 1, 8'd5, s);
        repeat (2) tick();
        start_exec = 1;
        exec_len = 8'd3;
        tick();
        start_exec = 0;
        wait_done("conflict");
        chk("conflict_n", nvalid, 8);
        chk("conflict_done", done_cyc, s + 9);
        repeat (3) tick();
        chk("conflict_busy", busy, 0);

        push(4'h1);
        push(4'h2);
        arm();
        start(0, 1, 8'd0, s);
        wait_done("len0");
        chk("len0_done", done_cyc, s + 1);
        chk("len0_n", nvalid, 0);
        chk("len0_empty", empty, 0);
        chk("sb_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/row_feeder.md
Name: row_feeder

Overview:
- West-edge driver for one row of the MAC array; produces the row's `in_w` data and `inst_w` instruction stream.
- Buffers incoming `bw`-bit words in an internal FIFO and sequences two operations:
  - kernel loading: `inst_w = 2'b01`, `col` words.
  - execute: `inst_w = 2'b10`, `exec_len` words.
- After execute it inserts a drain gap of `col` idle cycles so the last word propagates through all tiles before `done`.
- One instance per array row; outputs connect directly to the row's west data/instruction inputs.

Parameters:
- `bw`, 4, data word width (matches array `bw`)
- `col`, 8, tiles per row; kernel-load word count and drain length
- `depth`, 16, FIFO entries (power of two)
- `inst_bw`, 2, instruction width: [1]=execute, [0]=kernel loading

Ports:
- `clk`  input  1  clock, rising edge
- `reset`  input  1  asynchronous, active-low reset
- `wr`  input  1  push `in_data` into FIFO
- `in_data`  input  `bw`  word to buffer
- `full`  output  1  FIFO holds `depth` words
- `empty`  output  1  FIFO holds 0 words
- `start_load`  input  1  pulse: begin kernel load
- `start_exec`  input  1  pulse: begin execute
- `exec_len`  input  8  words to stream in execute; sampled with `start_exec`
- `out_w`  output  `bw`  data to row west input
- `inst_w`  output  `inst_bw`  instruction to row west input
- `busy`  output  1  high in any state other than IDLE
- `done`  output  1  one-cycle pulse at operation end

Behaviour:
- Reset (`reset` = 0, asynchronous):
  - FIFO pointers and count cleared; `empty` = 1, `full` = 0.
  - `out_w` = 0, `inst_w` = 00, `busy` = 0, `done` = 0, state = IDLE.
  - Asserting reset mid-operation aborts immediately; FIFO contents are discarded.
- FIFO:
  - Circular buffer; read and write pointers are log2(`depth`) bits and wrap modulo `depth`.
  - Occupancy count is log2(`depth`)+1 bits.
  - `wr` while not full: push accepted.
  - `wr` while full with a pop in the same cycle: push accepted, count unchanged.
  - `wr` while full and no pop: word dropped, state unchanged.
  - Pop only when not empty. Push and pop in the same cycle when empty: the pop is not performed; the word is stored.
- Outputs are registered. A word popped in cycle t appears on `out_w` with its `inst_w` in cycle t+1.
- State machine: IDLE, LOAD, EXEC, DRAIN, FIN.
  - IDLE:
    - `start_load` -> LOAD; remaining count = `col`.
    - Else `start_exec` -> EXEC with remaining count = `exec_len`; if `exec_len` = 0 go to FIN instead.
    - `start_load` and `start_exec` in the same cycle: load wins, exec is ignored.
    - Starts are ignored outside IDLE.
  - LOAD, each cycle:
    - FIFO not empty: pop, next `out_w` = word, next `inst_w` = 01, decrement count.
    - FIFO empty (stall): next `out_w` = 0, next `inst_w` = 00, count held.
    - Count reaching 0 on a pop -> FIN. The last word and the `done` pulse are on consecutive cycles.
  - EXEC:
    - Same as LOAD but with `inst_w` = 10.
    - Count reaching 0 -> DRAIN; drain counter = `col`.
  - DRAIN:
    - `out_w` = 0, `inst_w` = 00; counter decrements each cycle.
    - At 1 -> FIN, so exactly `col` idle cycles follow the last exec word.
  - FIN: `done` = 1 for one cycle, `busy` = 0 next cycle, -> IDLE.
- `busy` is high from the cycle after the accepted start through FIN, inclusive.
- `inst_w` is never 11. `out_w` is 0 whenever `inst_w` = 00.
- `wr` is accepted in every state, including during LOAD/EXEC pops.

Test Plan:
- Reset/idle:
  - Stimulus: pulse `reset` low mid-stream, then release.
  - Response: `out_w` = 0, `inst_w` = 00, `empty` = 1, `busy` = 0, `done` = 0; prior FIFO contents are gone.
- Kernel load:
  - Stimulus: push 1..8, then pulse `start_load`.
  - Response: `inst_w` = 01 with `out_w` = 1,2,...,8 on 8 consecutive cycles starting 1 cycle after start; `done` on the following cycle; `empty` = 1.
- Execute with drain:
  - Stimulus: push 10 words of 4'hA, `start_exec` with `exec_len` = 10.
  - Response: 10 cycles of `inst_w` = 10 / `out_w` = A, then 8 cycles of 00, then `done`. Total 19 cycles after the start cycle.
- Underflow stall:
  - Stimulus: push 3 words, `start_load`, push 5 more after 4 cycles.
  - Response: 3 words at 01, then 00 bubbles while empty, then the remaining 5 at 01. `done` only after the 8th word.
- FIFO boundaries:
  - Stimulus: push 17 words with no pop.
  - Response: `full` = 1 after 16; the 17th word is dropped.
  - Stimulus: then pop and push in the same cycle.
  - Response: count stays 16; pointer wrap keeps order, verified by a subsequent load.
- Start conflicts:
  - Stimulus: `start_load` and `start_exec` together.
  - Response: load only.
  - Stimulus: `start_exec` during LOAD.
  - Response: ignored.
  - Stimulus: `exec_len` = 0.
  - Response: `done` one cycle later, no 10 issued.
